// File: rtl/pc_source_reg.sv
// Registered PC-source selector with a one-entry redirect buffer, previous-PC and update counter.
// Optional alignment checking (and the align_err port) is enabled by defining PC_ALIGN_CHECK_EN.
module pc_source_reg #(
    parameter int                 WIDTH    = 32,
    parameter int                 NSRC     = 4,
    parameter int                 SELW     = 2,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [SELW-1:0]       PCSrc,
    input  logic [NSRC*WIDTH-1:0] in_bus,
    input  logic                  PCWrite,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_addr,
    output logic                  redirect_ready,
    output logic [WIDTH-1:0]      PC,
    output logic [WIDTH-1:0]      PrevPC,
    output logic                  sel_err,
    output logic [15:0]           upd_cnt
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                  align_err
`endif
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] pc_q, prev_q;
    logic [15:0]      cnt_q;
    logic             sel_err_q;

    logic [WIDTH-1:0] src_addr, cand;
    logic             src_ok, from_src, accept, sel_bad, misalign, commit;

    // Decode the select against only the implemented slots so an out-of-range
    // PCSrc never indexes past in_bus.
    always_comb begin
        src_addr = '0;
        src_ok   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (PCSrc == SELW'(k)) begin
                src_addr = in_bus[k*WIDTH +: WIDTH];
                src_ok   = 1'b1;
            end
        end
    end

    assign redirect_ready = (state_q == EMPTY);
    assign accept         = redirect_valid && redirect_ready;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cand     = src_addr;
        from_src = 1'b0;
        case (state_q)
            EMPTY: if (accept && !PCWrite) begin
                state_d = HELD;
                buf_d   = redirect_addr;
            end
            HELD:  if (PCWrite) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (state_q == HELD)  cand = buf_q;
        else if (accept)      cand = redirect_addr;
        else                  from_src = 1'b1;
    end

    assign sel_bad = PCWrite && from_src && !src_ok;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign = PCWrite && !sel_bad && (cand[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign commit  = PCWrite && !sel_bad && !misalign;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= EMPTY;
            buf_q     <= '0;
            pc_q      <= RESET_PC;
            prev_q    <= RESET_PC;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            if (sel_bad) sel_err_q <= 1'b1;
            if (commit) begin
                pc_q   <= cand;
                prev_q <= pc_q;
                cnt_q  <= cnt_q + 16'd1;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic align_err_q;
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)        align_err_q <= 1'b0;
        else if (misalign) align_err_q <= 1'b1;
    end
    assign align_err = align_err_q;
`endif

    assign PC      = pc_q;
    assign PrevPC  = prev_q;
    assign sel_err = sel_err_q;
    assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_pc_source_reg.sv
// Scoreboard bench for pc_source_reg (NSRC=3): driver queues hand-computed post-edge state,
// monitor pops and compares one entry after every rising edge.
module tb_pc_source_reg;

    localparam int W = 32;
    localparam int N = 3;
    localparam int S = 2;

    logic           CLK = 1'b0;
    logic           Reset = 1'b0;
    logic [S-1:0]   PCSrc = '0;
    logic [N*W-1:0] in_bus = '0;
    logic           PCWrite = 1'b0;
    logic           redirect_valid = 1'b0;
    logic [W-1:0]   redirect_addr = '0;
    logic           redirect_ready;
    logic [W-1:0]   PC, PrevPC;
    logic           sel_err;
    logic [15:0]    upd_cnt;
    logic           al_obs;

    pc_source_reg #(.WIDTH(W), .NSRC(N), .SELW(S), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .in_bus(in_bus), .PCWrite(PCWrite),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .redirect_ready(redirect_ready), .PC(PC), .PrevPC(PrevPC),
        .sel_err(sel_err), .upd_cnt(upd_cnt)
`ifdef PC_ALIGN_CHECK_EN
        , .align_err(al_obs)
`endif
    );
`ifndef PC_ALIGN_CHECK_EN
    assign al_obs = 1'b0;
`endif

    always #5 CLK = ~CLK;

    typedef struct {
        int          tag;
        logic [31:0] pc, prev;
        logic [15:0] cnt;
        logic        sel, rdy, al;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nfail = 0;
    int   step = 0;

    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nchk++;
            if (PC !== e.pc || PrevPC !== e.prev || upd_cnt !== e.cnt ||
                sel_err !== e.sel || redirect_ready !== e.rdy || al_obs !== e.al) begin
                nfail++;
                $display("FAIL step%0d: PC=%h want %h PrevPC=%h want %h cnt=%0d want %0d sel_err=%b want %b ready=%b want %b align_err=%b want %b",
                         e.tag, PC, e.pc, PrevPC, e.prev, upd_cnt, e.cnt, sel_err, e.sel,
                         redirect_ready, e.rdy, al_obs, e.al);
            end
        end
    end

    task automatic cyc(input logic pw, input logic [1:0] src, input logic rv,
                       input logic [31:0] ra, input logic [31:0] epc, input logic [31:0] eprev,
                       input logic [15:0] ecnt, input logic esel, input logic erdy,
                       input logic eal);
        exp_t e;
        @(negedge CLK);
        PCWrite = pw; PCSrc = src; redirect_valid = rv; redirect_addr = ra;
        e.tag = step; e.pc = epc; e.prev = eprev; e.cnt = ecnt;
        e.sel = esel; e.rdy = erdy; e.al = eal;
        q.push_back(e);
        step++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        PCWrite = 1'b0; redirect_valid = 1'b0;
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    initial begin
        in_bus[0*W +: W] = 32'h0000_0044;
        in_bus[1*W +: W] = 32'h0000_0100;
        in_bus[2*W +: W] = 32'h0000_0040;
        repeat (2) @(negedge CLK);
        chk("rst_pc", PC, 32'h0);
        chk("rst_prev", PrevPC, 32'h0);
        chk("rst_cnt", {16'h0, upd_cnt}, 32'h0);
        chk("rst_flags", {30'h0, sel_err, redirect_ready}, 32'h1);
        Reset = 1'b1;

        //   pw src rv addr           PC      PrevPC  cnt sel rdy al
        cyc(1, 2, 0, 32'h0,          32'h40,  32'h0,   1, 0, 1, 0);
        cyc(0, 0, 1, 32'h180,        32'h40,  32'h0,   1, 0, 0, 0);
        cyc(0, 0, 1, 32'h300,        32'h40,  32'h0,   1, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,          32'h180, 32'h40,  2, 0, 1, 0);
        cyc(1, 1, 1, 32'h200,        32'h200, 32'h180, 3, 0, 1, 0);
        cyc(1, 3, 0, 32'h0,          32'h200, 32'h180, 3, 1, 1, 0);
        cyc(1, 3, 1, 32'h204,        32'h204, 32'h200, 4, 1, 1, 0);
        cyc(1, 1, 0, 32'h0,          32'h100, 32'h204, 5, 1, 1, 0);
        cyc(0, 0, 1, 32'h180,        32'h100, 32'h204, 5, 1, 0, 0);

        // Asynchronous reset in the middle of a cycle while HELD.
        @(negedge CLK);
        redirect_valid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("async_pc", PC, 32'h0);
        chk("async_ready", {31'h0, redirect_ready}, 32'h1);
        chk("async_sel", {31'h0, sel_err}, 32'h0);
        @(negedge CLK);
        Reset = 1'b1;
        cyc(1, 0, 0, 32'h0,          32'h44,  32'h0,   1, 0, 1, 0);

`ifdef PC_ALIGN_CHECK_EN
        in_bus[0*W +: W] = 32'h0000_0042;
        cyc(1, 0, 0, 32'h0,          32'h44,  32'h0,   1, 0, 1, 1);
        cyc(0, 0, 1, 32'h182,        32'h44,  32'h0,   1, 0, 0, 1);
        cyc(1, 2, 0, 32'h0,          32'h44,  32'h0,   1, 0, 1, 1);
        cyc(1, 2, 1, 32'h186,        32'h44,  32'h0,   1, 0, 1, 1);
        @(negedge CLK);
        in_bus[0*W +: W] = 32'h0000_0044;
`endif

        // Counter wrap: exactly 65536 commits from reset, alternating slots 0 and 2.
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            logic [31:0] epc, eprev;
            epc   = (i % 2 == 0) ? 32'h44 : 32'h40;
            eprev = (i == 0) ? 32'h0 : ((i % 2 == 0) ? 32'h40 : 32'h44);
            cyc(1, (i % 2 == 0) ? 2'd0 : 2'd2, 0, 32'h0, epc, eprev, 16'(i + 1), 0, 1, 0);
        end
        @(negedge CLK);
        PCWrite = 1'b0;

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge CLK);
        if (q.size() > 0) begin
            nchk++;
            nfail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
